// File: rtl/decomp_fetch_scheduler.sv
// Round-robin refill scheduler: one 64-bit weight-memory read port shared by NUM_LANES decompressor lanes.
// Optional stall counter output (stall_cycles) is compiled in when DECOMP_FETCH_STATS_EN is defined.
module decomp_fetch_scheduler #(
   parameter int NUM_LANES = 4,
   parameter int AW        = 12,
   parameter int LW        = 10,
   parameter int RD_LAT    = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [NUM_LANES*AW-1:0] lane_base,
   input  logic [NUM_LANES*LW-1:0] lane_len,
   input  logic [NUM_LANES-1:0]    lane_req,
   output logic                    mem_rd_en,
   output logic [AW-1:0]           mem_addr,
   input  logic [63:0]             mem_rd_data,
   output logic [63:0]             lane_data,
   output logic [NUM_LANES-1:0]    lane_load,
   output logic [NUM_LANES-1:0]    lane_done,
   output logic                    busy,
   output logic                    done
`ifdef DECOMP_FETCH_STATS_EN
   ,
   output logic [31:0]             stall_cycles
`endif
);
   localparam int PW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
   localparam int CW = $clog2(RD_LAT + 1);

   typedef enum logic [1:0] {IDLE, ARB, WAIT, DELIVER} state_t;

   state_t                        state_q, state_d;
   logic [NUM_LANES-1:0][AW-1:0]  base_q, base_d;
   logic [NUM_LANES-1:0][LW-1:0]  len_q, len_d;
   logic [NUM_LANES-1:0][LW-1:0]  cnt_q, cnt_d;
   logic [NUM_LANES-1:0]          pending_q, pending_d;
   logic [NUM_LANES-1:0]          ldone_q, ldone_d;
   logic [NUM_LANES-1:0]          load_q, load_d;
   logic [PW-1:0]                 rr_q, rr_d;
   logic [PW-1:0]                 gnt_q, gnt_d;
   logic [PW-1:0]                 gnt_idx;
   logic [CW-1:0]                 wcnt_q, wcnt_d;
   logic [63:0]                   data_q, data_d;
   logic                          done_q, done_d;

   function automatic logic [PW-1:0] lane_wrap(input int v);
      return (v >= NUM_LANES) ? PW'(v - NUM_LANES) : PW'(v);
   endfunction

   // Scan downwards so the lowest offset from rr_q is the one left standing.
   always_comb begin
      gnt_idx = '0;
      for (int i = NUM_LANES - 1; i >= 0; i--) begin
         if (pending_q[lane_wrap(int'(rr_q) + i)]) gnt_idx = lane_wrap(int'(rr_q) + i);
      end
   end

   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      pending_d = pending_q;
      ldone_d   = ldone_q;
      load_d    = '0;
      rr_d      = rr_q;
      gnt_d     = gnt_q;
      wcnt_d    = wcnt_q;
      data_d    = data_q;
      done_d    = done_q;
      mem_rd_en = 1'b0;
      mem_addr  = '0;

      case (state_q)
         IDLE: begin
            if (start) begin
               base_d  = lane_base;
               len_d   = lane_len;
               cnt_d   = '0;
               rr_d    = '0;
               done_d  = 1'b0;
               state_d = ARB;
               for (int k = 0; k < NUM_LANES; k++) ldone_d[k] = (lane_len[k*LW +: LW] == '0);
            end
         end
         ARB: begin
            if (pending_q == '0) begin
               if (&ldone_q) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end else begin
               gnt_d     = gnt_idx;
               mem_rd_en = 1'b1;
               mem_addr  = base_q[gnt_idx] + AW'(cnt_q[gnt_idx]);
               wcnt_d    = CW'(RD_LAT - 1);
               state_d   = WAIT;
            end
         end
         WAIT: begin
            if (wcnt_q == '0) begin
               data_d         = mem_rd_data;
               load_d[gnt_q]  = 1'b1;
               state_d        = DELIVER;
            end else begin
               wcnt_d = wcnt_q - CW'(1);
            end
         end
         DELIVER: begin
            cnt_d[gnt_q] = cnt_q[gnt_q] + LW'(1);
            if ((cnt_q[gnt_q] + LW'(1)) == len_q[gnt_q]) ldone_d[gnt_q] = 1'b1;
            rr_d    = lane_wrap(int'(gnt_q) + 1);
            state_d = ARB;
         end
         default: state_d = IDLE;
      endcase

      // A request is tested against the post-delivery count so the final word never triggers a refetch.
      for (int k = 0; k < NUM_LANES; k++) begin
         if (state_q == IDLE) begin
            if (start) pending_d[k] = (lane_len[k*LW +: LW] != '0);
         end else begin
            if (state_q == DELIVER && gnt_q == PW'(k)) pending_d[k] = 1'b0;
            if (lane_req[k] && (cnt_d[k] < len_q[k])) pending_d[k] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         base_q    <= '0;
         len_q     <= '0;
         cnt_q     <= '0;
         pending_q <= '0;
         ldone_q   <= '0;
         load_q    <= '0;
         rr_q      <= '0;
         gnt_q     <= '0;
         wcnt_q    <= '0;
         data_q    <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
         ldone_q   <= ldone_d;
         load_q    <= load_d;
         rr_q      <= rr_d;
         gnt_q     <= gnt_d;
         wcnt_q    <= wcnt_d;
         data_q    <= data_d;
         done_q    <= done_d;
      end
   end

   assign lane_data = data_q;
   assign lane_load = load_q;
   assign lane_done = ldone_q;
   assign busy      = (state_q != IDLE);
   assign done      = done_q;

`ifdef DECOMP_FETCH_STATS_EN
   logic [31:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (state_q == IDLE && start) begin
         stall_d = '0;
      end else if (pending_q != '0 && state_q != ARB && stall_q != 32'hFFFF_FFFF) begin
         stall_d = stall_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) stall_q <= '0;
      else     stall_q <= stall_d;
   end

   assign stall_cycles = stall_q;
`endif
endmodule

// File: doc/decomp_fetch_scheduler.md
Name: decomp_fetch_scheduler

Overview:
- Shares one 64-bit compressed-weight memory read port between NUM_LANES decompressor lanes.
- Each lane raises a refill request when it has consumed its current 64-bit word. This block arbitrates the requests round-robin, generates the read address from a per-lane base and word count, and delivers the returned word to the requesting lane.
- Tracks per-lane stream length and reports per-lane and global completion.
- Sits between the weight SRAM and the decompressor array in the Res-DNN datapath.

Parameters:
- NUM_LANES, 4, number of decompressor lanes (2..16).
- AW, 12, memory word-address width.
- LW, 10, per-lane stream-length width (in 64-bit words).
- RD_LAT, 1, memory read latency in cycles (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a new job.
- lane_base  in  NUM_LANES*AW  per-lane start address; lane k is at [k*AW +: AW].
- lane_len  in  NUM_LANES*LW  per-lane word count; lane k is at [k*LW +: LW].
- lane_req  in  NUM_LANES  refill request from each lane (level or pulse).
- mem_rd_en  out  1  memory read strobe.
- mem_addr  out  AW  memory read address.
- mem_rd_data  in  64  read data, valid RD_LAT cycles after mem_rd_en.
- lane_data  out  64  registered word, broadcast to all lanes.
- lane_load  out  NUM_LANES  one-hot; lane k captures lane_data.
- lane_done  out  NUM_LANES  lane has received all lane_len words.
- busy  out  1  job in progress.
- done  out  1  sticky; all lanes complete.

Behaviour:
- Reset (async): all outputs 0, pending=0, counts=0, rr_ptr=0, state=IDLE.
- start is sampled only in IDLE; it is ignored while busy.
- On start:
  - Latch lane_base and lane_len.
  - cnt[k]=0.
  - pending[k]=(len[k]!=0), which primes the first word of every lane.
  - lane_done[k]=(len[k]==0).
  - done=0, busy=1, rr_ptr=0, go to ARB.
- Sticky request latch: pending[k] is set on lane_req[k]=1 when cnt[k]<len[k].
  - A request to an exhausted lane is dropped.
  - A request while pending[k] is already set does not double-count.
  - A request that arrives in the same cycle the lane's pending bit is cleared in DELIVER stays set, so a new fetch follows.
- States:
  - IDLE: busy=0.
  - ARB:
    - If pending==0 and all lane_done: set done=1 and go to IDLE.
    - Otherwise, if pending!=0: grant the first set bit at or after rr_ptr, wrapping modulo NUM_LANES. In the same cycle assert mem_rd_en=1 and mem_addr=base[g]+cnt[g] (wraps modulo 2^AW). Go to WAIT.
    - Otherwise stay in ARB.
  - WAIT: count RD_LAT cycles. In the last cycle, register mem_rd_data into lane_data. Go to DELIVER.
  - DELIVER:
    - lane_load[g]=1 for exactly one cycle; lane_data holds until the next delivery.
    - cnt[g]++, clear pending[g].
    - If cnt[g]+1==len[g], set lane_done[g].
    - rr_ptr=g+1, wrapping modulo NUM_LANES.
    - Go to ARB.
- Latency: ARB issue at cycle T; lane_load is visible at T+RD_LAT+1. One read is outstanding at a time, so the maximum throughput is one word per RD_LAT+2 cycles.
- mem_rd_en is asserted only in the ARB grant cycle.
- lane_load is never asserted outside DELIVER.
- rst asserted mid-job: everything clears immediately. An in-flight memory return is discarded and no lane_load is issued.
- done stays 1 until the next start or rst.

Optional Feature:
- Macro DECOMP_FETCH_STATS_EN.
- When defined, adds output port stall_cycles (32 bits):
  - Increments each cycle that pending!=0 and state!=ARB.
  - Saturates at 2^32-1.
  - Clears on start and on rst.
- When undefined, the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Prime: NUM_LANES=4, RD_LAT=1, base={0x000,0x100,0x200,0x300}, len={2,2,2,2}, start.
  - Expect mem_addr sequence 0x000,0x100,0x200,0x300.
  - Expect lane_load 0001,0010,0100,1000, each 2 cycles after its read.
- Round-robin: after prime, assert lane_req=1111 for 1 cycle.
  - Expect addresses 0x001,0x101,0x201,0x301 in lane order.
  - Then lane_done=1111, done=1, busy=0.
- Exhaustion/zero-length: len={0,1,3,1}.
  - Expect lane_done[0]=1 immediately at start.
  - A lane_req[1] after its single word gives no read.
  - Lane 2 gets exactly 3 words, at addresses base+0..2.
- Request collision: hold lane_req[2]=1 through its DELIVER cycle.
  - Expect a second fetch for lane 2 with address incremented by 1.
- Reset mid-WAIT: RD_LAT=3, assert rst during WAIT.
  - Expect no lane_load; all outputs 0.
  - Next start re-primes from cnt=0.
- Stats (DECOMP_FETCH_STATS_EN): 4 lanes pending at start, RD_LAT=1.
  - Expect stall_cycles increasing on every non-ARB cycle while pending!=0.
